// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage 16-bit pipeline.
// Generates per-stage enable/flush controls for load-use hazards, data-memory
// waits, taken branches, and freezes the pipeline after HALT reaches WB.
module pipe_hazard_ctrl #(
  parameter int REG_BITS    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_memread,
  input  logic                ex_regwrite,
  input  logic [REG_BITS-1:0] ex_dst_reg,
  input  logic                ex_branch_taken,
  input  logic                mem_req,
  input  logic                mem_done,
  input  logic                wb_halt,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                memwb_flush,
  output logic                halted,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       ms;
  logic       hold;

  // Saturating increment for the stall counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  assign lu = ex_memread & ex_regwrite &
              ((id_uses_rs & (id_rs == ex_dst_reg)) |
               (id_uses_rt & (id_rt == ex_dst_reg)));
  assign ms = mem_req & ~mem_done;

  // Freeze the upstream stages while a data-memory access is outstanding.
  assign hold = ((state == RUN) & ms) | ((state == MEM_WAIT) & ~mem_done);

  // Per-stage controls; branch beats load-use since the ID instruction is squashed.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (state == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (hold) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // State machine, wait-cycle timer, sticky flags and stall statistics.
  // The timer counts MEM_WAIT cycles; the MEM_TIMEOUT-th one without
  // mem_done is fatal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      halted       <= 1'b0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (state != HALTED && !pc_en)
        stall_cycles <= sat_inc(stall_cycles);
      case (state)
        RUN: begin
          wait_cnt <= 8'd0;
          if (wb_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (ms) begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (wb_halt) begin
            state    <= HALTED;
            halted   <= 1'b1;
            wait_cnt <= 8'd0;
          end else if (mem_done) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
            state       <= HALTED;
            halted      <= 1'b1;
            mem_timeout <= 1'b1;
            wait_cnt    <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_dst_reg;
  logic        id_uses_rs, id_uses_rt, ex_memread, ex_regwrite;
  logic        ex_branch_taken, mem_req, mem_done, wb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_flush;
  logic        halted, mem_timeout;
  logic [15:0] stall_cycles;
  logic [7:0]  ctl;

  int n_checks;
  int n_pass;

  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, memwb flushes}
  localparam logic [7:0] C_RUN    = 8'b11111_000;
  localparam logic [7:0] C_FREEZE = 8'b00001_001;
  localparam logic [7:0] C_BRANCH = 8'b11111_110;
  localparam logic [7:0] C_LU     = 8'b00111_010;
  localparam logic [7:0] C_HALT   = 8'b00000_000;

  pipe_hazard_ctrl #(.REG_BITS(3), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst_reg(ex_dst_reg),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_done(mem_done),
    .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic urs,
                       input logic urt, input logic mr, input logic rw, input logic [2:0] dst,
                       input logic br, input logic mq, input logic md, input logic wh);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_memread = mr; ex_regwrite = rw; ex_dst_reg = dst;
    ex_branch_taken = br; mem_req = mq; mem_done = md; wb_halt = wh;
  endtask

  task automatic idle();
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    idle();
    #1;
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_timeout", 32'(mem_timeout), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    check("reset_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    tick();
    rst = 1'b1;

    // Load-use on rs: one bubble
    drive(3'd3, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    tick();
    idle();
    check("lu_rs_stall", 32'(stall_cycles), 32'd1);
    #1 check("lu_rs_one_cycle", 32'(ctl), 32'(C_RUN));
    tick();

    // Load-use on rt
    drive(3'd1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    tick();
    // Matching register but not a register write: no hazard
    drive(3'd6, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("no_regwrite_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    // Matching register not actually read: no hazard
    drive(3'd2, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("unused_rs_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    check("neg_stall", 32'(stall_cycles), 32'd2);

    // Branch squashes a load-use
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("branch_lu_ctl", 32'(ctl), 32'(C_BRANCH));
    tick();
    idle();
    check("branch_stall", 32'(stall_cycles), 32'd2);

    // Memory wait: 4 frozen cycles, release on the 5th
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("memwait_freeze%0d", i), 32'(ctl), 32'(C_FREEZE));
      tick();
    end
    mem_done = 1'b1;
    #1 check("memwait_release", 32'(ctl), 32'(C_RUN));
    tick();
    idle();
    check("memwait_stall", 32'(stall_cycles), 32'd6);
    #1 check("memwait_back_run", 32'(ctl), 32'(C_RUN));
    tick();

    // Memory wait released with a held load-use in EX/ID
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("memwait_lu_freeze", 32'(ctl), 32'(C_FREEZE));
    tick();
    tick();
    mem_done = 1'b1;
    #1 check("memwait_release_lu", 32'(ctl), 32'(C_LU));
    tick();
    idle();
    check("memwait_lu_stall", 32'(stall_cycles), 32'd9);

    // Asynchronous reset in the middle of a memory wait
    mem_req = 1'b1;
    tick();
    tick();
    check("midstall_stall", 32'(stall_cycles), 32'd11);
    #2 rst = 1'b0;
    mem_req = 1'b0;
    #1;
    check("midrst_stall", 32'(stall_cycles), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_timeout", 32'(mem_timeout), 32'd0);
    check("midrst_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    rst = 1'b1;
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("postrst_lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    idle();
    check("postrst_stall", 32'(stall_cycles), 32'd1);

    // Halt: WB completes, then frozen regardless of inputs
    wb_halt = 1'b1;
    #1 check("halt_cycle_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    wb_halt = 1'b0;
    check("halted_set", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(3'(i), 3'(i), i[0], i[1], 1'b1, 1'b1, 3'(i), i[1], i[0], i[2], i[0]);
      #1 check($sformatf("halted_ctl%0d", i), 32'(ctl), 32'(C_HALT));
      tick();
    end
    check("halted_hold", 32'(halted), 32'd1);
    check("halted_stall", 32'(stall_cycles), 32'd1);

    // Reset out of HALTED, then a memory timeout
    idle();
    rst = 1'b0;
    #1 check("halt_rst_halted", 32'(halted), 32'd0);
    tick();
    rst = 1'b1;
    mem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 check($sformatf("to_freeze%0d", i), 32'(ctl), 32'(C_FREEZE));
      if (i == 15) check("to_not_yet", 32'(mem_timeout), 32'd0);
      tick();
    end
    check("to_timeout", 32'(mem_timeout), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_stall", 32'(stall_cycles), 32'd16);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("to_halt_ctl%0d", i), 32'(ctl), 32'(C_HALT));
      tick();
    end
    check("to_sticky", 32'(mem_timeout), 32'd1);
    check("to_stall_frozen", 32'(stall_cycles), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
